// File: rtl/uvmt_cv32e40s_base_tb_pkg.sv
// Shared types and helpers for the OBI integrity checker.
// Holds the tracking FSM states and the rchk reference calculation.
package uvmt_cv32e40s_base_tb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } obi_state_e;

    localparam int RCHK_BYTES   = 4;
    localparam int RCHK_ERR_BIT = 4;
    localparam int RCHK_WIDTH   = 5;

    // One parity bit per rdata byte, plus err carried straight through.
    function automatic logic [RCHK_WIDTH-1:0] calc_rchk(
        input logic [31:0] rdata,
        input logic        err
    );
        logic [RCHK_WIDTH-1:0] chk;
        chk = '0;
        for (int i = 0; i < RCHK_BYTES; i++) begin
            chk[i] = ^rdata[8*i +: 8];
        end
        chk[RCHK_ERR_BIT] = err;
        return chk;
    endfunction

endpackage

// File: rtl/uvmt_cv32e40s_sat_counter.sv
// Saturating up-counter used for the per-class error tallies.
// Sticks at all-ones instead of wrapping.
module uvmt_cv32e40s_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uvmt_cv32e40s_obi_integrity_checker.sv
// Passive OBI checker: handshake parity, rchk and outstanding protocol.
// All error pulses appear one cycle after the offending cycle.
module uvmt_cv32e40s_obi_integrity_checker
    import uvmt_cv32e40s_base_tb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_WIDTH       = 16,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_i,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic                 err_i,
    input  logic                 reqpar_i,
    input  logic                 gntpar_i,
    input  logic                 rvalidpar_i,
    input  logic [31:0]          rdata_i,
    input  logic [4:0]           rchk_i,
    output logic [OW-1:0]        outstanding_o,
    output logic                 err_hs_par_o,
    output logic                 err_rchk_o,
    output logic                 err_proto_o,
    output logic                 err_sticky_o,
    output logic [CNT_WIDTH-1:0] cnt_hs_par_o,
    output logic [CNT_WIDTH-1:0] cnt_rchk_o,
    output logic [CNT_WIDTH-1:0] cnt_proto_o
);

    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    obi_state_e    state;
    obi_state_e    state_next;
    logic [OW-1:0] out_next;
    logic          grant;
    logic          hs_next;
    logic          rchk_next;
    logic          proto_next;

    assign grant = req_i & gnt_i;

    // Parity lines are complementary, so equality means corruption.
    assign hs_next = (reqpar_i == req_i) |
                     (gntpar_i == gnt_i) |
                     (rvalidpar_i == rvalid_i);

    assign rchk_next = rvalid_i &&
                       (rchk_i != calc_rchk(rdata_i, err_i));

    always_comb begin
        state_next = state;
        out_next   = outstanding_o;
        proto_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (rvalid_i) begin
                    proto_next = 1'b1;
                end
                if (grant && !rvalid_i) begin
                    out_next   = OW'(1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (grant && !rvalid_i) begin
                    if (outstanding_o == MAX_CNT) begin
                        proto_next = 1'b1;
                    end else begin
                        out_next = outstanding_o + 1'b1;
                    end
                end else if (rvalid_i && !grant) begin
                    out_next = outstanding_o - 1'b1;
                    if (outstanding_o == OW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            outstanding_o <= '0;
            err_hs_par_o  <= 1'b0;
            err_rchk_o    <= 1'b0;
            err_proto_o   <= 1'b0;
            err_sticky_o  <= 1'b0;
        end else begin
            state         <= state_next;
            outstanding_o <= out_next;
            err_hs_par_o  <= hs_next;
            err_rchk_o    <= rchk_next;
            err_proto_o   <= proto_next;
            if (hs_next || rchk_next || proto_next) begin
                err_sticky_o <= 1'b1;
            end
        end
    end

    uvmt_cv32e40s_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_hs_par (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (hs_next),
        .count (cnt_hs_par_o)
    );

    uvmt_cv32e40s_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_rchk (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (rchk_next),
        .count (cnt_rchk_o)
    );

    uvmt_cv32e40s_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_proto (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (proto_next),
        .count (cnt_proto_o)
    );

endmodule
